// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// the NOP payload constants and the lane zeroing helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Widest lane payload the zeroing helper handles; lanes are cast to and from this width.
    localparam int LANE_MAX_W = 128;

    // NOP payload fields: an all-zero word with every write enable deasserted.
    localparam logic [LANE_MAX_W-1:0] ZERO_WORD  = '0;
    localparam logic                  WR_DISABLE = 1'b0;

    // An invalid lane is stored as a NOP so stale write enables never leak downstream.
    function automatic logic [LANE_MAX_W-1:0] lane_nop_fill(
        input logic                  lane_valid,
        input logic [LANE_MAX_W-1:0] lane_data
    );
        return lane_valid ? lane_data : ZERO_WORD;
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One payload lane of a stage register: load enable, clear, and zero-on-invalid capture.
module pipe_lane_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next lane contents: clear wins over load, otherwise hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = WR_DISABLE;
            data_d  = DATA_W'(ZERO_WORD);
        end else if (load) begin
            valid_d = in_valid;
            data_d  = DATA_W'(lane_nop_fill(in_valid, LANE_MAX_W'(in_data)));
        end
    end

    // Lane storage.
    always_ff @(posedge clk) begin
        // NOTE: the payload is reset as well as the valid bit because out_data must read zero after reset.
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// flush, NOP lane zeroing, occupancy status and a saturating stall counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LANES   = 1,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_mask,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_mask,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    pipe_state_e state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic accept, emit;
    logic main_load, main_from_skid, main_clr;
    logic skid_load, skid_clr;
    logic [LANES-1:0]        skid_mask;
    logic [LANES*DATA_W-1:0] skid_data;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    // Handshake state machine: decides the next state and which entry loads from where.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept && SKID_EN != 0) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state_d        = ST_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Whatever an entry stops holding is zeroed, so an empty output always reads as a NOP.
        main_clr = (state_d == ST_EMPTY);
        skid_clr = (state_d != ST_SKID);
    end

    // Stall counter: one per cycle a bundle waits at the output, pinned at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State and counter registers; flush leaves the counter alone.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if (SKID_EN != 0) begin : g_skid_ready
        logic in_ready_q, in_ready_d;

        // Registered ready keeps out_ready off any combinational path into in_ready.
        always_comb in_ready_d = (state_d != ST_SKID);

        // Ready flop, asserted straight out of reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_comb_ready
        assign in_ready = !out_valid || out_ready;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pipe_lane_reg #(.DATA_W(DATA_W)) u_skid (
            .clk       (clk),
            .rst       (rst),
            .clr       (skid_clr),
            .load      (skid_load),
            .in_valid  (in_lane_mask[l]),
            .in_data   (in_data[l*DATA_W +: DATA_W]),
            .out_valid (skid_mask[l]),
            .out_data  (skid_data[l*DATA_W +: DATA_W])
        );

        pipe_lane_reg #(.DATA_W(DATA_W)) u_main (
            .clk       (clk),
            .rst       (rst),
            .clr       (main_clr),
            .load      (main_load),
            .in_valid  (main_from_skid ? skid_mask[l] : in_lane_mask[l]),
            .in_data   (main_from_skid ? skid_data[l*DATA_W +: DATA_W]
                                       : in_data[l*DATA_W +: DATA_W]),
            .out_valid (out_lane_mask[l]),
            .out_data  (out_data[l*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a skid instance (2 lanes, 4-bit counter) and a
// no-skid instance, both checked every cycle against a bundle-queue model.
module tb_pipe_skid_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: LANES=2, DATA_W=16, SKID_EN=1, CNT_W=4
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_mask, a_out_mask, a_occ;
    logic [31:0] a_data, a_out_data;
    logic [3:0]  a_stall;

    // Instance B: LANES=1, DATA_W=16, SKID_EN=0, CNT_W=16
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]  b_mask, b_out_mask;
    logic [1:0]  b_occ;
    logic [15:0] b_data, b_out_data;
    logic [15:0] b_stall;

    pipe_skid_stage #(.DATA_W(16), .LANES(2), .SKID_EN(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_lane_mask(a_mask), .in_data(a_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_lane_mask(a_out_mask), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_skid_stage #(.DATA_W(16), .LANES(1), .SKID_EN(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_lane_mask(b_mask), .in_data(b_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_lane_mask(b_out_mask), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each stage is a FIFO of bundles {mask, zeroed data}; head is the output.
    logic [33:0] qa[$];
    logic [16:0] qb[$];
    int stall_a = 0;
    int stall_b = 0;
    bit model_live = 1'b0;

    function automatic logic [33:0] nop_a(input logic [1:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        for (int l = 0; l < 2; l++) if (!m[l]) r[l*16 +: 16] = 16'h0;
        return {m, r};
    endfunction

    task automatic compare();
        int sa, sb;
        logic [33:0] ha;
        logic [16:0] hb;
        sa = qa.size();
        sb = qb.size();
        check("a_in_ready",  64'(a_in_ready),  64'(sa < 2));
        check("a_out_valid", 64'(a_out_valid), 64'(sa > 0));
        check("a_occupancy", 64'(a_occ),       64'(sa));
        check("a_stall_cnt", 64'(a_stall),     64'(stall_a));
        if (sa > 0) begin
            ha = qa[0];
            check("a_out_data", 64'(a_out_data), 64'(ha[31:0]));
            check("a_out_mask", 64'(a_out_mask), 64'(ha[33:32]));
        end
        check("b_in_ready",  64'(b_in_ready),  64'(sb == 0 || b_out_ready));
        check("b_out_valid", 64'(b_out_valid), 64'(sb > 0));
        check("b_occupancy", 64'(b_occ),       64'(sb));
        check("b_stall_cnt", 64'(b_stall),     64'(stall_b));
        if (sb > 0) begin
            hb = qb[0];
            check("b_out_data", 64'(b_out_data), 64'(hb[15:0]));
            check("b_out_mask", 64'(b_out_mask), 64'(hb[16]));
        end
    endtask

    task automatic model_update();
        bit acc, em;
        if (rst) begin
            qa.delete();
            qb.delete();
            stall_a = 0;
            stall_b = 0;
            model_live = 1'b1;
        end else begin
            acc = a_in_valid && (qa.size() < 2);
            em  = (qa.size() > 0) && a_out_ready;
            if (qa.size() > 0 && !a_out_ready && stall_a < 15) stall_a++;
            if (a_flush) qa.delete();
            else begin
                if (em) void'(qa.pop_front());
                if (acc) qa.push_back(nop_a(a_mask, a_data));
            end

            acc = b_in_valid && (qb.size() == 0 || b_out_ready);
            em  = (qb.size() > 0) && b_out_ready;
            if (qb.size() > 0 && !b_out_ready && stall_b < 65535) stall_b++;
            if (b_flush) qb.delete();
            else begin
                if (em) void'(qb.pop_front());
                if (acc) qb.push_back({b_mask[0], b_mask[0] ? b_data : 16'h0});
            end
        end
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic cycle();
        #1;
        if (model_live) compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [1:0] m, input logic [31:0] d,
                           input logic ordy, input logic fl);
        a_in_valid  = v;
        a_mask      = m;
        a_data      = d;
        a_out_ready = ordy;
        a_flush     = fl;
    endtask

    task automatic drive_b(input logic v, input logic [15:0] d, input logic ordy);
        b_in_valid  = v;
        b_mask      = 1'b1;
        b_data      = d;
        b_out_ready = ordy;
        b_flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        drive_b(1'b0, 16'h0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_a_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_data",  64'(a_out_data),  64'd0);
        check("rst_a_out_mask",  64'(a_out_mask),  64'd0);
        check("rst_a_occ",       64'(a_occ),       64'd0);
        check("rst_a_stall",     64'(a_stall),     64'd0);

        // Stream 1,2,3 with no backpressure: one-cycle latency, no stalls.
        for (int v = 1; v <= 3; v++) begin
            drive_a(1'b1, 2'b11, 32'(v), 1'b1, 1'b0);
            cycle();
            check("stream_data", 64'(a_out_data), 64'(v));
            check("stream_occ",  64'(a_occ),       64'd1);
        end
        drive_a(1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
        cycle();
        check("stream_drained", 64'(a_out_valid), 64'd0);
        check("stream_stall",   64'(a_stall),     64'd0);

        // Backpressure into the skid entry, then release.
        drive_a(1'b1, 2'b11, 32'hA, 1'b0, 1'b0);
        cycle();
        check("bp_occ1", 64'(a_occ), 64'd1);
        drive_a(1'b1, 2'b11, 32'hB, 1'b0, 1'b0);
        cycle();
        check("bp_occ2",  64'(a_occ),       64'd2);
        check("bp_ready", 64'(a_in_ready),  64'd0);
        check("bp_hold",  64'(a_out_data),  64'hA);
        drive_a(1'b0, 2'b11, 32'h0, 1'b0, 1'b0);
        cycle();
        cycle();
        check("bp_hold2", 64'(a_out_data), 64'hA);
        drive_a(1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
        cycle();
        check("bp_second", 64'(a_out_data), 64'hB);
        cycle();
        check("bp_empty", 64'(a_out_valid), 64'd0);
        check("bp_stall", 64'(a_stall),     64'd3);

        // Lane masking: lane 0 invalid reads back as zero.
        drive_a(1'b1, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cycle();
        check("mask_data", 64'(a_out_data), 64'hDEAD_0000);
        check("mask_bits", 64'(a_out_mask), 64'd2);
        // All-NOP bundle is still transferred.
        drive_a(1'b1, 2'b00, 32'h1234_5678, 1'b1, 1'b0);
        cycle();
        check("nop_valid", 64'(a_out_valid), 64'd1);
        check("nop_data",  64'(a_out_data),  64'd0);
        drive_a(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        cycle();

        // Flush while in SKID; the bundle offered alongside the flush is dropped.
        drive_a(1'b1, 2'b11, 32'h11, 1'b0, 1'b0);
        cycle();
        drive_a(1'b1, 2'b11, 32'h22, 1'b0, 1'b0);
        cycle();
        check("fl_pre_occ", 64'(a_occ), 64'd2);
        drive_a(1'b1, 2'b11, 32'hC, 1'b0, 1'b1);
        cycle();
        check("fl_valid", 64'(a_out_valid), 64'd0);
        check("fl_occ",   64'(a_occ),       64'd0);
        check("fl_ready", 64'(a_in_ready),  64'd1);
        check("fl_data",  64'(a_out_data),  64'd0);
        check("fl_stall", 64'(a_stall),     64'd5);
        drive_a(1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
        cycle();
        check("fl_no_c", 64'(a_out_valid), 64'd0);

        // Saturation of the 4-bit stall counter.
        drive_a(1'b1, 2'b01, 32'h77, 1'b0, 1'b0);
        cycle();
        drive_a(1'b0, 2'b01, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle();
        check("sat_stall", 64'(a_stall), 64'd15);
        drive_a(1'b0, 2'b01, 32'h0, 1'b1, 1'b0);
        cycle();
        check("sat_hold", 64'(a_stall), 64'd15);

        // No-skid instance: in_ready tracks out_ready combinationally while full.
        drive_b(1'b1, 16'h55, 1'b0);
        cycle();
        for (int i = 0; i < 6; i++) begin
            logic r;
            r = 1'(i % 2);
            drive_b(1'b1, 16'(16'h60 + i), r);
            #1;
            check("b_ready_follows", 64'(b_in_ready), 64'(r));
            check("b_occ_max1",      64'(b_occ <= 2'd1), 64'd1);
            cycle();
        end
        drive_b(1'b0, 16'h0, 1'b1);
        cycle();

        // Randomized traffic on both instances, with one mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            rst = (i == 300);
            drive_a($urandom_range(0, 3) != 0, 2'($urandom), $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            b_in_valid  = $urandom_range(0, 3) != 0;
            b_mask      = 1'($urandom);
            b_data      = 16'($urandom);
            b_out_ready = $urandom_range(0, 2) != 0;
            b_flush     = $urandom_range(0, 40) == 0;
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generalised inter-stage pipeline register for the CPU pipeline, intended for EX/MEM, MEM/WB and future dual-issue stage boundaries.
- Carries LANES independent payload lanes of DATA_W bits, moved together as one bundle.
- Uses a valid/ready handshake in place of a global stall vector, with an optional one-entry skid buffer that keeps throughput at one bundle per cycle under backpressure.
- Adds synchronous flush, NOP zeroing of invalid lanes, occupancy status and a saturating stall-cycle counter.

Parameters:
- DATA_W, 32: payload bits per lane (write address, enables, data, etc. are packed by the instantiating stage).
- LANES, 1: number of payload lanes per bundle (1..4).
- SKID_EN, 1: 1 = registered in_ready with skid entry; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all held and incoming bundles
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  stage can accept a bundle
- in_lane_mask  input  LANES  per-lane valid within the bundle
- in_data  input  LANES*DATA_W  lane payloads, lane 0 in the LSBs
- out_valid  output  1  bundle present at the output
- out_ready  input  1  downstream accepts the bundle
- out_lane_mask  output  LANES  per-lane valid of the output bundle
- out_data  output  LANES*DATA_W  output payloads
- occupancy  output  2  number of held bundles (0..2)
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready. Payloads are captured only on accept.
- Reset (rst=1 at posedge):
  - out_valid=0, out_lane_mask=0, out_data=0.
  - Skid entry cleared; occupancy=0; stall_cnt=0.
  - in_ready=1 after the reset edge.
  - Reset mid-transfer drops everything held.
- Lane zeroing: on capture, any lane whose mask bit is 0 has its payload stored as all-zero, i.e. a NOP with write disables clear. out_data of an invalid lane is always 0.
- Latency: an accepted bundle appears at the output on the next cycle, so minimum latency is one cycle.
- If accept and emit fall in the same cycle in the FULL state, the new bundle replaces the old one with no bubble.
- States for SKID_EN=1 (in_ready = registered, equal to state != SKID):
  - EMPTY: accept -> FULL (main register loaded).
  - FULL:
    - accept & emit -> FULL, main register reloaded.
    - accept & !out_ready -> SKID, incoming bundle stored in the skid entry.
    - !accept & emit -> EMPTY, out_valid=0: this is the bubble.
    - Otherwise hold.
  - SKID: in_ready=0. Emit -> FULL, skid entry moved into the main register. Otherwise hold both entries.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Only EMPTY and FULL states exist; occupancy never exceeds 1.
- Flush:
  - Priority is below rst and above everything else.
  - The next state is EMPTY, outputs are zeroed, and the skid entry is cleared.
  - A bundle presented in the flush cycle is discarded even if in_ready=1.
  - stall_cnt is unchanged by flush.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_lane_mask must hold stable.
- A bundle with in_valid=1 and in_lane_mask=0 is a legal all-NOP bundle and is transferred normally.
- stall_cnt increments by 1 each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1 and never wraps.
- occupancy: EMPTY=0, FULL=1, SKID=2.
- No combinational path from out_ready to in_ready when SKID_EN=1.

Decomposition:
- Shared package pipe_pkg holds:
  - State encoding: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - Lane-mask zeroing function.
  - The existing zero-word and write-disable constants, reused as the NOP payload fields.
- One sub-module is natural: pipe_lane_reg, a per-lane DATA_W register with load enable and zero-on-invalid, instantiated LANES times for the main register and LANES times for the skid entry.

Test Plan:
- Reset then stream: rst for 2 cycles, then in_valid=1 every cycle with out_ready=1 and data 0x1,0x2,0x3 -> out_data shows 0x1,0x2,0x3 on consecutive cycles, one cycle behind input; occupancy=1; stall_cnt=0.
- Backpressure (SKID_EN=1): send 0xA then 0xB with out_ready=0 -> occupancy 1 then 2; in_ready=0; out_data holds 0xA. Raise out_ready -> 0xA, then 0xB, then out_valid=0; stall_cnt equals the held cycles.
- Lane masking (LANES=2): in_lane_mask=2'b10, in_data={0xDEAD,0xBEEF} -> out_data={0xDEAD,0x0000}, out_lane_mask=2'b10.
- Flush in SKID state: hold two bundles, assert flush with in_valid=1 data 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never appears; stall_cnt retained.
- Saturation (CNT_W=4): hold out_valid with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- SKID_EN=0: with out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle; occupancy never exceeds 1.
